// File: rtl/adder_pkg.sv
// Shared definitions for the fully_pipelined_adder and its downstream result collector.
package adder_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 4;
  localparam int PTR_W     = $clog2(DEPTH_DEF);

  typedef struct packed {
    logic                 carry;
    logic [WIDTH_DEF-1:0] sum;
  } result_t;

  // WIDTH carry-ripple stages plus the output register.
  function automatic int adder_latency(input int width);
    return width + 1;
  endfunction

  // Keeps a one-entry FIFO from collapsing to a zero-width pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/adder_result_collector_if.sv
// Adder-side handshake, stall and result signals of the result collector.
interface adder_result_collector_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic                       adder_en;
  logic [WIDTH-1:0]           adder_s;
  logic                       adder_c;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH:0]             out_data;
  logic [$clog2(DEPTH+1)-1:0] count;

  modport slave (
    input  in_valid, adder_s, adder_c, out_ready,
    output in_ready, adder_en, out_valid, out_data, count
  );

  modport master (
    output in_valid, adder_s, adder_c, out_ready,
    input  in_ready, adder_en, out_valid, out_data, count
  );
endinterface

// File: rtl/adder_result_collector_sync_fifo.sv
// Synchronous FIFO with a registered head (no fall-through); push into a full FIFO
// is accepted only when a pop happens on the same edge.
module sync_fifo
  import adder_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           dout
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: storage is not reset; count and the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: non-blocking assignments let dout read the pre-edge mem/rd_ptr while they update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);

      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Head register: next stored entry, or the incoming word when it becomes the head.
      if (do_pop) begin
        if (count > CW'(1))  dout <= mem[next_ptr(rd_ptr)];
        else if (do_push)    dout <= din;
      end else if (do_push && empty) begin
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/adder_result_collector.sv
// Valid-token tracking and stall control for fully_pipelined_adder, with results
// collected into a FIFO and presented on a valid/ready handshake.
module adder_result_collector
  import adder_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input logic                      clk,
  input logic                      rst,
  adder_result_collector_if.slave  bus
);

  localparam int LATENCY = adder_latency(WIDTH);

  logic [LATENCY-1:0]         vld;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       push;
  logic                       pop;
  logic                       en;
  logic [WIDTH:0]             head;
  logic [$clog2(DEPTH+1)-1:0] occupancy;

  // Stall only when a real result would exit into a full FIFO that is not draining.
  // out_ready reaches adder_en combinationally.
  assign pop  = !fifo_empty && bus.out_ready;
  assign en   = !(vld[LATENCY-1] && fifo_full && !pop);
  assign push = en && vld[LATENCY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     vld <= '0;
    else if (en) vld <= {vld[LATENCY-2:0], bus.in_valid};
  end

  sync_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({bus.adder_c, bus.adder_s}),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy),
    .dout  (head)
  );

  assign bus.adder_en  = en;
  assign bus.in_ready  = en;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = head;
  assign bus.count     = occupancy;

endmodule

// File: tb/tb_adder_result_collector.sv
// Directed bench: collector paired with a behavioural 5-register stallable adder (WIDTH=4, DEPTH=4).
module tb_adder_result_collector;
  import adder_pkg::*;

  localparam int W   = 4;
  localparam int D   = 4;
  localparam int LAT = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [W-1:0] op_a   = '0;
  logic [W-1:0] op_b   = '0;
  logic         op_cin = 1'b0;

  adder_result_collector_if #(.WIDTH(W), .DEPTH(D)) bus ();

  adder_result_collector #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Adder model: no reset, all registers advance together on en.
  result_t pipe [LAT];
  always @(posedge clk) begin
    if (bus.adder_en) begin
      pipe[0] <= result_t'({1'b0, op_a} + {1'b0, op_b} + {4'b0, op_cin});
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign bus.adder_s = pipe[LAT-1].sum;
  assign bus.adder_c = pipe[LAT-1].carry;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  logic [W:0] exp_q [$];
  logic [W:0] out_log [$];
  int         arr_q [$];
  int         n_out = 0;
  int         stall_cnt = 0;
  int         last_issue = 0;

  // Output monitor: every accepted result must be the oldest outstanding one.
  initial forever begin
    @(negedge clk);
    if (!rst && bus.out_valid && bus.out_ready) begin
      check("out_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("out_order", bus.out_data, exp_q.pop_front());
      out_log.push_back(bus.out_data);
      arr_q.push_back(cyc);
      n_out++;
    end
  end

  task automatic clear_logs();
    out_log.delete();
    arr_q.delete();
    n_out = 0;
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the operand handshake edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    bit done = 0;
    op_a = a; op_b = b; op_cin = ci;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back({1'b0, a} + {1'b0, b} + {4'b0, ci});
        last_issue = cyc;
        done = 1;
      end else begin
        stall_cnt++;
      end
      @(posedge clk); #1;
    end
    check("issue_accepted", done, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_outs(input int n, input int budget, input string tag);
    for (int k = 0; k < budget && n_out < n; k++) begin
      @(posedge clk); #1;
    end
    check(tag, n_out, n);
  endtask

  task automatic wait_full_stall(input string tag);
    bit seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (bus.count == D && !bus.adder_en) seen = 1;
    end
    check(tag, seen, 1);
  endtask

  logic [W:0] h1;
  int         t0;

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_adder_en", bus.adder_en, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_count", bus.count, 0);
    @(posedge clk); #1;

    // 1: single op 3+5+0 = 0_1000
    clear_logs();
    bus.out_ready = 1'b1;
    issue(4'd3, 4'd5, 1'b0);
    t0 = last_issue;
    wait_outs(1, 20, "t1_outs");
    if (arr_q.size() > 0) check("t1_latency", arr_q[0] - t0, LAT + 1);
    if (out_log.size() > 0) check("t1_data", out_log[0], 5'b0_1000);
    check("t1_count_after", bus.count, 0);
    check("t1_valid_after", bus.out_valid, 0);

    // 2: 16 back-to-back ops i + (15-i) + 1 = 1_0000
    clear_logs();
    stall_cnt = 0;
    for (int i = 0; i < 16; i++) issue(4'(i), 4'(15 - i), 1'b1);
    check("t2_no_stall", stall_cnt, 0);
    wait_outs(16, 40, "t2_outs");
    for (int i = 0; i < out_log.size(); i++) check("t2_data", out_log[i], 5'b1_0000);
    for (int i = 1; i < arr_q.size(); i++) check("t2_spacing", arr_q[i] - arr_q[i-1], 1);

    // 3: backpressure with 10 ops (a=i, b=i+5, cin=i&1); first result 0+5+0 = 5
    clear_logs();
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) issue(4'(i), 4'(i + 5), 1'(i & 1));
      end
      begin
        wait_full_stall("t3_stall_seen");
        check("t3_count", bus.count, 4);
        check("t3_in_ready", bus.in_ready, 0);
        check("t3_head", bus.out_data, 5'd5);
        repeat (3) @(negedge clk);
        check("t3_hold_count", bus.count, 4);
        check("t3_hold_en", bus.adder_en, 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_outs(10, 60, "t3_outs");
    check("t3_drained", exp_q.size(), 0);

    // 4: full FIFO, token exiting, one-cycle pop (results 3,4,5,6,7,8)
    clear_logs();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) issue(4'(i + 2), 4'd1, 1'b0);
    wait_full_stall("t4_stall_seen");
    h1 = exp_q[1];
    check("t4_head_before", bus.out_data, 5'd3);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t4_en_during_pop", bus.adder_en, 1);
    check("t4_count_during_pop", bus.count, 4);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("t4_count_after", bus.count, 4);
    check("t4_head_after", bus.out_data, h1);
    check("t4_en_after", bus.adder_en, 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_outs(6, 40, "t4_outs");
    check("t4_drained", exp_q.size(), 0);

    // 5: bubbles 1,0,0,1,0,1 -> results 3, 15, 31 spaced 3 then 2 cycles
    clear_logs();
    issue(4'd1, 4'd2, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    issue(4'd7, 4'd7, 1'b1);
    @(posedge clk); #1;
    issue(4'd15, 4'd15, 1'b1);
    wait_outs(3, 30, "t5_outs");
    if (out_log.size() == 3) begin
      check("t5_data0", out_log[0], 5'h03);
      check("t5_data1", out_log[1], 5'h0F);
      check("t5_data2", out_log[2], 5'h1F);
      check("t5_gap0", arr_q[1] - arr_q[0], 3);
      check("t5_gap1", arr_q[2] - arr_q[1], 2);
    end
    repeat (4) begin @(posedge clk); #1; end
    check("t5_no_extra", n_out, 3);

    // 6: reset with 2 stored results and 3 tokens in flight
    clear_logs();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) issue(4'(i), 4'd1, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    check("t6_pre_count", bus.count, 2);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", bus.out_valid, 0);
    check("t6_rst_count", bus.count, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    check("t6_no_stale", n_out, 0);
    issue(4'd9, 4'd4, 1'b1);
    t0 = last_issue;
    wait_outs(1, 20, "t6_outs");
    if (arr_q.size() > 0) check("t6_latency", arr_q[0] - t0, LAT + 1);
    if (out_log.size() > 0) check("t6_data", out_log[0], 5'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
